// File: rtl/comparator_bist.sv
// Built-in self test for a 4-bit magnitude comparator.
// Sweeps all 256 {A,B} operand pairs. Each pair is held for SETTLE cycles,
// then the comparator's gt/lt/eq response is checked against the ideal one.
// Reports a count of failing pairs and captures the first failing pair.
module comparator_bist #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] A,
  output logic [3:0] B,
  input  logic       AgtB,
  input  logic       AltB,
  input  logic       AeqB,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [8:0] err_count,
  output logic       fail_valid,
  output logic [3:0] fail_a,
  output logic [3:0] fail_b
);

  // SETTLING is the per-vector wait state; it is not called SETTLE because
  // that name is already taken by the parameter.
  typedef enum logic [1:0] {
    IDLE,
    SETTLING,
    CHECK,
    DONE
  } state_t;

  localparam logic [3:0] SettleLoad = 4'(SETTLE - 1);

  state_t      state;
  state_t      nextState;
  logic [7:0]  idx;
  logic [3:0]  waitCount;
  logic [8:0]  errCount;
  logic        failValid;
  logic [3:0]  failA;
  logic [3:0]  failB;
  logic        expGt;
  logic        expLt;
  logic        expEq;
  logic        vectorFails;

  // The operands come straight from the index register, so they are registered.
  assign A = idx[7:4];
  assign B = idx[3:0];

  // Expected response of an ideal unsigned comparator. Any bit that differs,
  // including a response that is not one-hot, marks the vector as failing.
  assign expGt       = (A > B);
  assign expLt       = (A < B);
  assign expEq       = (A == B);
  assign vectorFails = ({AgtB, AltB, AeqB} != {expGt, expLt, expEq});

  assign busy       = (state == SETTLING) || (state == CHECK);
  assign done       = (state == DONE);
  assign pass       = done && (errCount == 9'd0);
  assign err_count  = errCount;
  assign fail_valid = failValid;
  assign fail_a     = failA;
  assign fail_b     = failB;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic: start is honoured only from IDLE or DONE.
  always_comb begin
    nextState = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          nextState = SETTLING;
        end
      end
      SETTLING: begin
        if (waitCount == 4'd0) begin
          nextState = CHECK;
        end
      end
      CHECK: begin
        if (idx == 8'hFF) begin
          nextState = DONE;
        end else begin
          nextState = SETTLING;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Sweep datapath: vector index, settle counter, error count and first-failure capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= 8'd0;
      waitCount <= 4'd0;
      errCount  <= 9'd0;
      failValid <= 1'b0;
      failA     <= 4'd0;
      failB     <= 4'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            idx       <= 8'd0;
            waitCount <= SettleLoad;
            errCount  <= 9'd0;
            failValid <= 1'b0;
            failA     <= 4'd0;
            failB     <= 4'd0;
          end
        end
        SETTLING: begin
          if (waitCount != 4'd0) begin
            waitCount <= waitCount - 4'd1;
          end
        end
        CHECK: begin
          if (vectorFails) begin
            if (errCount != 9'd256) begin
              errCount <= errCount + 9'd1;
            end
            if (!failValid) begin
              failValid <= 1'b1;
              failA     <= A;
              failB     <= B;
            end
          end
          if (idx != 8'hFF) begin
            idx       <= idx + 8'd1;
            waitCount <= SettleLoad;
          end
        end
        default: begin
          idx <= idx;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_bist.sv
// Self-checking bench for comparator_bist.
// A behavioural comparator with selectable faults feeds the SETTLE=2 instance.
// A second instance with SETTLE=1 sees an ideal comparator.
module tb_comparator_bist;

  typedef struct {
    int         mode;
    int         expErr;
    logic [3:0] expFa;
    logic [3:0] expFb;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       start0;
  logic       start1;
  logic [3:0] A0, B0, A1, B1;
  logic       gt0, lt0, eq0, gt1, lt1, eq1;
  logic       busy0, done0, pass0, fv0;
  logic       busy1, done1, pass1, fv1;
  logic [8:0] err0, err1;
  logic [3:0] fa0, fb0, fa1, fb1;
  int         faultMode;
  int         checks;
  int         errors;
  vec_t       vecs[8];

  comparator_bist #(.SETTLE(2)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .A(A0), .B(B0),
    .AgtB(gt0), .AltB(lt0), .AeqB(eq0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_valid(fv0), .fail_a(fa0), .fail_b(fb0)
  );

  comparator_bist #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .A(A1), .B(B1),
    .AgtB(gt1), .AltB(lt1), .AeqB(eq1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_valid(fv1), .fail_a(fa1), .fail_b(fb1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator under test for dut0, with injectable faults.
  always_comb begin
    gt0 = (A0 > B0);
    lt0 = (A0 < B0);
    eq0 = (A0 == B0);
    case (faultMode)
      1: eq0 = 1'b0;
      2: begin gt0 = (A0 < B0); lt0 = (A0 > B0); end
      3: begin gt0 = !(A0 > B0); lt0 = !(A0 < B0); eq0 = !(A0 == B0); end
      4: if (A0 == B0) gt0 = 1'b1;
      5: if (A0 == 4'h9 && B0 == 4'h3) lt0 = 1'b1;
      6: if (B0 == 4'hF) eq0 = !(A0 == B0);
      7: if (A0 == 4'hF && B0 == 4'hF) gt0 = 1'b1;
      default: ;
    endcase
  end

  // Ideal comparator for dut1.
  always_comb begin
    gt1 = (A1 > B1);
    lt1 = (A1 < B1);
    eq1 = (A1 == B1);
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One-cycle start pulse on dut0; returns at the negedge after the sampling edge.
  task automatic applyStimulus();
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  // Counts rising edges until done0; optionally re-pulses start at edge midAt.
  task automatic waitDone0(input int midAt, output int cycles);
    int n;
    n = 0;
    while (!done0 && n < 5000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start0 = (n == midAt);
    end
    start0 = 1'b0;
    if (!done0) begin
      errors++;
      $display("[TB] FAIL doneTimeout: got done=0 after %0d cycles, expected done=1", n);
    end
    cycles = n;
  endtask

  task automatic checkResetState0(input string tag);
    checkOutput({tag, "_A"}, A0, 0);
    checkOutput({tag, "_B"}, B0, 0);
    checkOutput({tag, "_busy"}, busy0, 0);
    checkOutput({tag, "_done"}, done0, 0);
    checkOutput({tag, "_pass"}, pass0, 0);
    checkOutput({tag, "_err"}, err0, 0);
    checkOutput({tag, "_fv"}, fv0, 0);
    checkOutput({tag, "_fa"}, fa0, 0);
    checkOutput({tag, "_fb"}, fb0, 0);
  endtask

  initial begin
    int cycles;
    int n;
    int bad;
    int expIdx;
    string tag;

    vecs[0] = '{0, 0,   4'h0, 4'h0};
    vecs[1] = '{1, 16,  4'h0, 4'h0};
    vecs[2] = '{2, 240, 4'h0, 4'h1};
    vecs[3] = '{3, 256, 4'h0, 4'h0};
    vecs[4] = '{4, 16,  4'h0, 4'h0};
    vecs[5] = '{5, 1,   4'h9, 4'h3};
    vecs[6] = '{6, 16,  4'h0, 4'hF};
    vecs[7] = '{7, 1,   4'hF, 4'hF};

    checks = 0;
    errors = 0;
    faultMode = 0;
    rst = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    checkResetState0("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("idleHoldBusy", busy0, 0);
    checkOutput("idleHoldDone", done0, 0);

    for (int i = 0; i < 8; i++) begin
      faultMode = vecs[i].mode;
      tag = $sformatf("mode%0d", vecs[i].mode);
      applyStimulus();
      checkOutput({tag, "_busyAfterStart"}, busy0, 1);
      waitDone0(-1, cycles);
      checkOutput({tag, "_cycles"}, cycles, 768);
      checkOutput({tag, "_err"}, err0, vecs[i].expErr);
      checkOutput({tag, "_pass"}, pass0, (vecs[i].expErr == 0) ? 1 : 0);
      checkOutput({tag, "_fv"}, fv0, (vecs[i].expErr != 0) ? 1 : 0);
      checkOutput({tag, "_fa"}, fa0, vecs[i].expFa);
      checkOutput({tag, "_fb"}, fb0, vecs[i].expFb);
      checkOutput({tag, "_busyInDone"}, busy0, 0);
      checkOutput({tag, "_finalAB"}, {A0, B0}, 8'hFF);
    end

    // Start from DONE after a failing sweep clears the results.
    faultMode = 0;
    applyStimulus();
    checkOutput("restartErrCleared", err0, 0);
    checkOutput("restartFvCleared", fv0, 0);
    checkOutput("restartBusy", busy0, 1);
    checkOutput("restartDoneLow", done0, 0);
    waitDone0(-1, cycles);
    checkOutput("restartCycles", cycles, 768);
    checkOutput("restartPass", pass0, 1);

    // Start pulsed mid-sweep must not restart it.
    applyStimulus();
    waitDone0(50, cycles);
    checkOutput("midStartCycles", cycles, 768);
    checkOutput("midStartErr", err0, 0);

    // Reset asserted mid-sweep, then a clean sweep.
    faultMode = 2;
    applyStimulus();
    repeat (100) @(negedge clk);
    checkOutput("preResetErrNonzero", (err0 != 0) ? 1 : 0, 1);
    rst = 1'b1;
    #1;
    checkResetState0("midReset");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("postResetIdle", busy0, 0);
    faultMode = 0;
    applyStimulus();
    waitDone0(-1, cycles);
    checkOutput("postResetCycles", cycles, 768);
    checkOutput("postResetErr", err0, 0);
    checkOutput("postResetPass", pass0, 1);

    // SETTLE=1: operands step every 2 cycles, done after 512 cycles.
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 0;
    bad = 0;
    while (!done1 && n < 3000) begin
      expIdx = (n / 2 > 255) ? 255 : n / 2;
      if ({A1, B1} != expIdx[7:0]) bad++;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    checkOutput("settle1AbStepErrors", bad, 0);
    checkOutput("settle1Cycles", n, 512);
    checkOutput("settle1Done", done1, 1);
    checkOutput("settle1Pass", pass1, 1);
    checkOutput("settle1Err", err1, 0);
    checkOutput("settle1Fv", fv1, 0);
    checkOutput("settle1FinalAB", {A1, B1}, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
